pc_fetch_ctrl: RTL and testbench

Fetch sequencer that owns the program counter and drives instruction-memory fetches for the single-issue RISC-V core. It holds one outstanding request at a time and buffers the returned word until decode accepts it. It applies branch/jump redirects and trap redirects, with traps taking priority, and squashes any in-flight fetch made stale by a redirect.

---
 rtl/pc_fetch_ctrl.sv | 130 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one instruction-memory request at a time,
// buffers the returned word for decode and applies branch/trap redirects.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap_valid,
  output logic        misalign_fault,
  output logic [31:0] pc_out,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

  state_t      state;
  logic        kill;
  logic        redir;
  logic        misalign;
  logic [31:0] target;

  // Traps win over branches; a misaligned branch target is turned into a trap.
  always_comb begin
    redir    = trap_valid | redirect_valid;
    misalign = ~trap_valid & redirect_valid & (redirect_pc[1:0] != 2'b00);
    target   = (trap_valid | misalign) ? TRAP_VEC : redirect_pc;
  end

  assign imem_addr = pc_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= BOOT;
      pc_out         <= RESET_PC;
      imem_req       <= 1'b0;
      if_valid       <= 1'b0;
      if_instr       <= NOP;
      if_pc          <= RESET_PC;
      misalign_fault <= 1'b0;
      fetch_count    <= 32'd0;
      kill           <= 1'b0;
    end else begin
      misalign_fault <= 1'b0;
      case (state)
        BOOT: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end

        REQ: begin
          if (redir) begin
            pc_out         <= target;
            misalign_fault <= misalign;
          end
          if (imem_gnt) begin
            state    <= WAIT;
            imem_req <= 1'b0;
            // A request granted in the redirect cycle fetched the old address.
            kill     <= redir;
          end
        end

        WAIT: begin
          if (redir) begin
            pc_out         <= target;
            misalign_fault <= misalign;
            if (imem_rvalid) begin
              state    <= REQ;
              imem_req <= 1'b1;
              kill     <= 1'b0;
            end else begin
              kill <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (kill) begin
              kill     <= 1'b0;
              state    <= REQ;
              imem_req <= 1'b1;
            end else begin
              if_instr <= imem_rdata;
              if_pc    <= pc_out;
              if_valid <= 1'b1;
              state    <= HOLD;
            end
          end
        end

        HOLD: begin
          // An accept in the redirect cycle still counts; the redirect source
          // squashes that instruction downstream.
          if (if_ready) begin
            fetch_count <= fetch_count + 32'd1;
          end
          if (redir) begin
            if_valid       <= 1'b0;
            pc_out         <= target;
            misalign_fault <= misalign;
            state          <= REQ;
            imem_req       <= 1'b1;
          end else if (if_ready) begin
            if_valid <= 1'b0;
            pc_out   <= pc_out + 32'd4;
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end

        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: the bench plays instruction memory and
// decode, pushing expected (pc, instr) pairs and comparing them at if_valid.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        trap_valid = 1'b0;
  logic        misalign_fault;
  logic [31:0] pc_out;
  logic [31:0] fetch_count;

  pc_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .misalign_fault (misalign_fault),
    .pc_out         (pc_out),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_count = 32'd0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (imem_req !== 1'b0 || pc_out !== 32'h0 || imem_addr !== 32'h0 ||
        if_valid !== 1'b0 || if_instr !== 32'h13 || if_pc !== 32'h0 ||
        misalign_fault !== 1'b0 || fetch_count !== 32'h0) begin
      errors++;
      $display("FAIL %s: req=%b pc=%h addr=%h valid=%b instr=%h ifpc=%h fault=%b cnt=%0d, required 0/0/0/0/13/0/0/0",
               name, imem_req, pc_out, imem_addr, if_valid, if_instr, if_pc, misalign_fault, fetch_count);
    end else begin
      $display("%s: outputs at reset values", name);
    end
  endtask

  task automatic wait_req(input logic [31:0] addr, output int waited);
    waited = 0;
    while (imem_req !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout: imem_req=%b after %0d cycles, required 1 at addr %h", imem_req, waited, addr);
    end else if (imem_addr !== addr) begin
      errors++;
      $display("FAIL req_addr: imem_addr=%h, required %h", imem_addr, addr);
    end else begin
      $display("req addr=%h after %0d cycles", imem_addr, waited);
    end
  endtask

  // Grant in the request cycle, return data one cycle later, check the buffer.
  task automatic grant_and_return(input logic [31:0] addr, input logic [31:0] instr);
    exp_t e;
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL req_drop: imem_req=%b in WAIT, required 0", imem_req);
    end
    e.pc = addr;
    e.instr = instr;
    sb.push_back(e);
    imem_rvalid = 1'b1;
    imem_rdata = instr;
    step();
    imem_rvalid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr) begin
      errors++;
      $display("FAIL fetch_data: valid=%b pc=%h instr=%h, required 1 %h %h", if_valid, if_pc, if_instr, e.pc, e.instr);
    end else begin
      $display("fetch pc=%h instr=%h", if_pc, if_instr);
    end
  endtask

  task automatic accept();
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    exp_count++;
    checks++;
    if (fetch_count !== exp_count || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL accept: count=%0d valid=%b, required %0d 0", fetch_count, if_valid, exp_count);
    end else begin
      $display("accept count=%0d", fetch_count);
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    check_reset_values("reset_hold");
    reset = 1'b1;
    #1;
    check_reset_values("reset_release_boot");
  endtask

  task automatic test_back_to_back();
    int w;
    wait_req(32'h0, w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL boot_latency: first req after %0d cycles, required 1", w);
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        wait_req(32'(i * 4), w);
        checks++;
        if (w != 0) begin
          errors++;
          $display("FAIL loop_latency: next req after %0d extra cycles, required 0", w);
        end
      end
      grant_and_return(32'(i * 4), 32'hA000_0000 + 32'(i));
      accept();
    end
  endtask

  task automatic test_backpressure();
    int w;
    wait_req(32'hC, w);
    grant_and_return(32'hC, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_instr !== 32'h1234_5678 || imem_req !== 1'b0 || pc_out !== 32'hC) begin
        errors++;
        $display("FAIL backpressure: valid=%b instr=%h req=%b pc=%h, required 1 12345678 0 0000000c",
                 if_valid, if_instr, imem_req, pc_out);
      end
    end
    $display("backpressure held 5 cycles");
    accept();
  endtask

  task automatic test_redirect_wait();
    int w;
    wait_req(32'h10, w);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (pc_out !== 32'h200 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL redirect_wait_pc: pc=%h req=%b, required 00000200 0", pc_out, imem_req);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
      end
      step();
      imem_rvalid = 1'b0;
      checks++;
      if (if_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_data: if_valid=%b instr=%h, required 0", if_valid, if_instr);
      end
    end
    $display("stale fetch squashed");
    wait_req(32'h200, w);
    grant_and_return(32'h200, 32'h0000_0200);
    accept();
  endtask

  task automatic test_trap_priority();
    int w;
    wait_req(32'h204, w);
    grant_and_return(32'h204, 32'h0000_0204);
    trap_valid = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    step();
    trap_valid = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if (pc_out !== 32'h100 || misalign_fault !== 1'b0 || if_valid !== 1'b0 || fetch_count !== exp_count) begin
      errors++;
      $display("FAIL trap_priority: pc=%h fault=%b valid=%b cnt=%0d, required 00000100 0 0 %0d",
               pc_out, misalign_fault, if_valid, fetch_count, exp_count);
    end else begin
      $display("trap redirect pc=%h", pc_out);
    end
    wait_req(32'h100, w);
    grant_and_return(32'h100, 32'h0000_0100);
    accept();
  endtask

  task automatic test_misalign();
    int w;
    redirect_valid = 1'b1;
    redirect_pc = 32'h202;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (misalign_fault !== 1'b1 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL misalign_pulse: fault=%b addr=%h req=%b, required 1 00000100 1", misalign_fault, imem_addr, imem_req);
    end else begin
      $display("misalign fault addr=%h", imem_addr);
    end
    step();
    checks++;
    if (misalign_fault !== 1'b0) begin
      errors++;
      $display("FAIL misalign_width: fault=%b second cycle, required 0", misalign_fault);
    end
    wait_req(32'h100, w);
    grant_and_return(32'h100, 32'h0000_0101);
    accept();
  endtask

  task automatic test_hold_redirect_accept();
    int w;
    wait_req(32'h104, w);
    grant_and_return(32'h104, 32'h0000_0104);
    redirect_valid = 1'b1;
    redirect_pc = 32'h400;
    if_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    if_ready = 1'b0;
    exp_count++;
    checks++;
    if (fetch_count !== exp_count || pc_out !== 32'h400 || if_valid !== 1'b0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL hold_redirect: cnt=%0d pc=%h valid=%b req=%b, required %0d 00000400 0 1",
               fetch_count, pc_out, if_valid, imem_req, exp_count);
    end else begin
      $display("hold redirect with accept pc=%h count=%0d", pc_out, fetch_count);
    end
  endtask

  task automatic test_wrap();
    int w;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    wait_req(32'hFFFF_FFFC, w);
    grant_and_return(32'hFFFF_FFFC, 32'h0000_FFFC);
    accept();
    wait_req(32'h0, w);
  endtask

  task automatic test_reset_mid_fetch();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_values("reset_in_wait");
    exp_count = 32'd0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    step();
    reset = 1'b1;
    step();
    step();
    imem_rvalid = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_count !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_rvalid: valid=%b req=%b addr=%h cnt=%0d, required 0 1 0 0",
               if_valid, imem_req, imem_addr, fetch_count);
    end else begin
      $display("pending rvalid after reset ignored");
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_redirect_wait();
    test_trap_priority();
    test_misalign();
    test_hold_redirect_accept();
    test_wrap();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
